// File: rtl/gshare_branch_tracker_pkg.sv
// ----------------------------------------------------------------------------
// gshare_pkg
// Shared types for the gshare in-flight branch tracker.
//   PC_W / HIST_W  : default widths of branch pc and global-history snapshot
//   slot_state_e   : lifecycle of one tracker slot
//   slot_t         : payload captured at prediction time and completed at resolve
// ----------------------------------------------------------------------------
package gshare_pkg;

    localparam int PC_W   = 7;
    localparam int HIST_W = 7;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } slot_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] history;
        logic              pred_taken;
        logic              actual_taken;
    } slot_t;

endpackage

// File: rtl/gshare_branch_tracker_if.sv
// ----------------------------------------------------------------------------
// gshare_branch_tracker_if
// Bundles the predict (alloc), resolve and train channels of the tracker.
//   master : fetch / resolve / predictor side (drives alloc_* and resolve_*)
//   slave  : the tracker itself (drives alloc_ready/tag, train_*, count,
//            resolve_err)
// ----------------------------------------------------------------------------
interface gshare_branch_tracker_if #(
    parameter int PC_W   = gshare_pkg::PC_W,
    parameter int HIST_W = gshare_pkg::HIST_W,
    parameter int DEPTH  = 8
);
    localparam int TAG_W = $clog2(DEPTH);

    logic              alloc_valid;
    logic              alloc_ready;
    logic [PC_W-1:0]   alloc_pc;
    logic [HIST_W-1:0] alloc_history;
    logic              alloc_pred_taken;
    logic [TAG_W-1:0]  alloc_tag;

    logic              resolve_valid;
    logic [TAG_W-1:0]  resolve_tag;
    logic              resolve_taken;

    logic              train_valid;
    logic [PC_W-1:0]   train_pc;
    logic [HIST_W-1:0] train_history;
    logic              train_taken;
    logic              train_mispredicted;

    logic [TAG_W:0]    count;
    logic              resolve_err;

    modport master (
        output alloc_valid, alloc_pc, alloc_history, alloc_pred_taken,
        output resolve_valid, resolve_tag, resolve_taken,
        input  alloc_ready, alloc_tag,
        input  train_valid, train_pc, train_history, train_taken, train_mispredicted,
        input  count, resolve_err
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_history, alloc_pred_taken,
        input  resolve_valid, resolve_tag, resolve_taken,
        output alloc_ready, alloc_tag,
        output train_valid, train_pc, train_history, train_taken, train_mispredicted,
        output count, resolve_err
    );

endinterface

// File: rtl/gshare_tracker_slot_ram.sv
// ----------------------------------------------------------------------------
// gshare_tracker_slot_ram
// DEPTH x slot_t register array holding the payload of every tracked branch.
//   clk          : clock
//   we_i/waddr_i/wdata_i          : full-slot write (alloc)
//   upd_en_i/upd_addr_i/upd_taken_i : actual-direction update (resolve)
//   raddr_i/rdata_o               : asynchronous read (head slot)
// Slot validity lives in the top, so the data needs no reset.
// ----------------------------------------------------------------------------
module gshare_tracker_slot_ram
    import gshare_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [TAG_W-1:0] waddr_i,
    input  slot_t            wdata_i,
    input  logic             upd_en_i,
    input  logic [TAG_W-1:0] upd_addr_i,
    input  logic             upd_taken_i,
    input  logic [TAG_W-1:0] raddr_i,
    output slot_t            rdata_o
);

    slot_t mem_q [DEPTH];

    // Alloc writes an EMPTY slot and resolve updates a PENDING one, so the
    // two ports never target the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (upd_en_i) begin
            mem_q[upd_addr_i].actual_taken <= upd_taken_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/gshare_branch_tracker.sv
// ----------------------------------------------------------------------------
// gshare_branch_tracker
// In-flight branch tracker between fetch-side prediction and gshare training.
// Captures each predicted branch in a circular buffer, hands back a tag,
// accepts resolutions by tag in any order and retires in program order with
// one registered train transaction per cycle. A mispredicted retirement
// squashes every younger entry.
//   clk, areset : clock, synchronous active-high reset
//   bus (slave) : alloc / resolve / train channels plus count and resolve_err
// ----------------------------------------------------------------------------
module gshare_branch_tracker #(
    parameter int PC_W   = gshare_pkg::PC_W,
    parameter int HIST_W = gshare_pkg::HIST_W,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    areset,
    gshare_branch_tracker_if.slave  bus
);
    import gshare_pkg::*;

    localparam int TAG_W = $clog2(DEPTH);
    localparam int PTR_W = TAG_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    slot_state_e      state_q [DEPTH];
    slot_state_e      state_d [DEPTH];

    logic [PC_W-1:0]   train_pc_q;
    logic [HIST_W-1:0] train_history_q;
    logic              train_valid_q, train_taken_q, train_mispredicted_q;
    logic              resolve_err_q;

    logic [TAG_W-1:0] head_idx, tail_idx;
    slot_t            head_slot, alloc_slot;
    logic             full, retire, squash_now, alloc_fire;
    logic             resolve_pending, resolve_accept, resolve_bad;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];

    // Wrap bits differing with equal indices means the writer lapped the reader.
    assign full = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

    assign retire     = (state_q[head_idx] == RESOLVED);
    assign squash_now = retire && (head_slot.pred_taken != head_slot.actual_taken);

    assign alloc_fire = bus.alloc_valid && bus.alloc_ready;

    // A resolve that lands on a PENDING slot during a squash is for a branch
    // that is being thrown away, so it is quietly dropped rather than flagged.
    assign resolve_pending = (state_q[bus.resolve_tag] == PENDING);
    assign resolve_accept  = bus.resolve_valid && resolve_pending && !squash_now;
    assign resolve_bad     = bus.resolve_valid && !resolve_pending;

    assign alloc_slot = '{pc:           bus.alloc_pc,
                          history:      bus.alloc_history,
                          pred_taken:   bus.alloc_pred_taken,
                          actual_taken: 1'b0};

    gshare_tracker_slot_ram #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_slot_ram (
        .clk         (clk),
        .we_i        (alloc_fire),
        .waddr_i     (tail_idx),
        .wdata_i     (alloc_slot),
        .upd_en_i    (resolve_accept),
        .upd_addr_i  (bus.resolve_tag),
        .upd_taken_i (bus.resolve_taken),
        .raddr_i     (head_idx),
        .rdata_o     (head_slot)
    );

    // Slot lifecycle and pointer update. Squash is applied last so it wipes
    // everything except the head retirement and rewinds tail behind it.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (resolve_accept) begin
            state_d[bus.resolve_tag] = RESOLVED;
        end
        if (alloc_fire) begin
            state_d[tail_idx] = PENDING;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (retire) begin
            state_d[head_idx] = EMPTY;
            head_d            = head_q + PTR_W'(1);
        end
        if (squash_now) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_d[i] = EMPTY;
            end
            tail_d = head_q + PTR_W'(1);
        end
    end

    // State registers; train payload holds its last value between retirements.
    always_ff @(posedge clk) begin
        if (areset) begin
            head_q               <= '0;
            tail_q               <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= EMPTY;
            end
            train_valid_q        <= 1'b0;
            train_pc_q           <= '0;
            train_history_q      <= '0;
            train_taken_q        <= 1'b0;
            train_mispredicted_q <= 1'b0;
            resolve_err_q        <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            state_q       <= state_d;
            train_valid_q <= retire;
            if (retire) begin
                train_pc_q           <= head_slot.pc;
                train_history_q      <= head_slot.history;
                train_taken_q        <= head_slot.actual_taken;
                train_mispredicted_q <= squash_now;
            end
            resolve_err_q <= resolve_err_q | resolve_bad;
        end
    end

    assign bus.alloc_ready        = !full && !squash_now;
    assign bus.alloc_tag          = tail_idx;
    assign bus.count              = tail_q - head_q;
    assign bus.train_valid        = train_valid_q;
    assign bus.train_pc           = train_pc_q;
    assign bus.train_history      = train_history_q;
    assign bus.train_taken        = train_taken_q;
    assign bus.train_mispredicted = train_mispredicted_q;
    assign bus.resolve_err        = resolve_err_q;

endmodule

// File: tb/tb_gshare_branch_tracker.sv
// ----------------------------------------------------------------------------
// tb_gshare_branch_tracker
// Self-checking bench for gshare_branch_tracker: a table of branches driven
// through alloc/resolve, hand-written sequences for full, squash and reset,
// and a scoreboard of expected train transactions in program order.
// ----------------------------------------------------------------------------
module tb_gshare_branch_tracker;

    localparam int PC_W   = 7;
    localparam int HIST_W = 7;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;

    logic clk;
    logic areset;

    gshare_branch_tracker_if #(.PC_W(PC_W), .HIST_W(HIST_W), .DEPTH(DEPTH)) bus ();

    gshare_branch_tracker #(.PC_W(PC_W), .HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hist;
        logic              taken;
        logic              mis;
    } train_t;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hist;
        logic              pred;
        logic              actual;
        logic [TAG_W-1:0]  expTag;
    } vec_t;

    train_t expQ[$];
    train_t monExp;
    vec_t   vecs[6];
    int     resolveOrder[6];
    int     nCompared   = 0;
    int     nMismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single place where a comparison is counted and reported.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of alloc/resolve inputs, then return them to idle.
    task automatic applyStimulus(input logic aV, input logic [PC_W-1:0] pc,
                                 input logic [HIST_W-1:0] hist, input logic pred,
                                 input logic rV, input logic [TAG_W-1:0] rTag,
                                 input logic rTaken);
        bus.alloc_valid      = aV;
        bus.alloc_pc         = pc;
        bus.alloc_history    = hist;
        bus.alloc_pred_taken = pred;
        bus.resolve_valid    = rV;
        bus.resolve_tag      = rTag;
        bus.resolve_taken    = rTaken;
        cycle();
        bus.alloc_valid      = 1'b0;
        bus.resolve_valid    = 1'b0;
    endtask

    task automatic doAlloc(input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] hist,
                           input logic pred, input logic [TAG_W-1:0] expTag,
                           input logic actual, input bit pushExp);
        checkOutput("alloc_ready", 32'(bus.alloc_ready), 32'd1);
        checkOutput("alloc_tag", 32'(bus.alloc_tag), 32'(expTag));
        if (pushExp) expQ.push_back('{pc, hist, actual, pred != actual});
        applyStimulus(1'b1, pc, hist, pred, 1'b0, '0, 1'b0);
    endtask

    task automatic doResolve(input logic [TAG_W-1:0] tag, input logic taken);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, tag, taken);
    endtask

    task automatic doReset(input int n);
        areset = 1'b1;
        repeat (n) cycle();
        areset = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    endtask

    // Scoreboard: every train pulse must match the oldest outstanding branch.
    always @(negedge clk) begin
        if (bus.train_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_train: got train pc %0d, expected no train",
                         bus.train_pc);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("train_pc", 32'(bus.train_pc), 32'(monExp.pc));
                checkOutput("train_history", 32'(bus.train_history), 32'(monExp.hist));
                checkOutput("train_taken", 32'(bus.train_taken), 32'(monExp.taken));
                checkOutput("train_mispredicted", 32'(bus.train_mispredicted),
                            32'(monExp.mis));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        areset               = 1'b1;
        bus.alloc_valid      = 1'b0;
        bus.alloc_pc         = '0;
        bus.alloc_history    = '0;
        bus.alloc_pred_taken = 1'b0;
        bus.resolve_valid    = 1'b0;
        bus.resolve_tag      = '0;
        bus.resolve_taken    = 1'b0;

        vecs[0] = '{7'd0, 7'h11, 1'b1, 1'b1, 3'd0};
        vecs[1] = '{7'd1, 7'h22, 1'b1, 1'b1, 3'd1};
        vecs[2] = '{7'd2, 7'h05, 1'b0, 1'b0, 3'd2};
        vecs[3] = '{7'd3, 7'h7f, 1'b1, 1'b1, 3'd3};
        vecs[4] = '{7'd4, 7'h40, 1'b0, 1'b0, 3'd4};
        vecs[5] = '{7'd5, 7'h0a, 1'b1, 1'b1, 3'd5};
        resolveOrder = '{5, 4, 3, 2, 1, 0};

        // Reset state
        doReset(2);
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        checkOutput("rst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
        checkOutput("rst_train_valid", 32'(bus.train_valid), 32'd0);
        checkOutput("rst_resolve_err", 32'(bus.resolve_err), 32'd0);

        // Single branch, mispredicted, with resolve-to-train latency
        doAlloc(7'd3, 7'd0, 1'b0, 3'd0, 1'b1, 1'b1);
        checkOutput("t1_count", 32'(bus.count), 32'd1);
        doResolve(3'd0, 1'b1);
        checkOutput("t1_train_not_yet", 32'(bus.train_valid), 32'd0);
        cycle();
        checkOutput("t1_train_valid", 32'(bus.train_valid), 32'd1);
        checkOutput("t1_count_after", 32'(bus.count), 32'd0);
        waitDrain(5);

        // Table: allocate all, resolve youngest first, expect back-to-back retirement
        doReset(1);
        for (int i = 0; i < 6; i++)
            doAlloc(vecs[i].pc, vecs[i].hist, vecs[i].pred, vecs[i].expTag,
                    vecs[i].actual, 1'b1);
        checkOutput("t2_count", 32'(bus.count), 32'd6);
        for (int k = 0; k < 6; k++)
            doResolve(vecs[resolveOrder[k]].expTag, vecs[resolveOrder[k]].actual);
        checkOutput("t2_train_not_yet", 32'(bus.train_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            checkOutput($sformatf("t2_train_pulse%0d", i), 32'(bus.train_valid), 32'd1);
        end
        cycle();
        checkOutput("t2_train_idle", 32'(bus.train_valid), 32'd0);
        checkOutput("t2_count_empty", 32'(bus.count), 32'd0);
        waitDrain(4);

        // Full buffer, dropped alloc, wrap of the tag after one retirement
        doReset(1);
        for (int i = 0; i < 8; i++)
            doAlloc(7'(16 + i), 7'(i), 1'(i), 3'(i), 1'(i), 1'b1);
        checkOutput("t3_full_ready", 32'(bus.alloc_ready), 32'd0);
        checkOutput("t3_full_count", 32'(bus.count), 32'd8);
        applyStimulus(1'b1, 7'd99, 7'd0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("t3_dropped_count", 32'(bus.count), 32'd8);
        doResolve(3'd0, 1'b0);
        checkOutput("t3_ready_before_retire", 32'(bus.alloc_ready), 32'd0);
        cycle();
        checkOutput("t3_ready_after_retire", 32'(bus.alloc_ready), 32'd1);
        checkOutput("t3_count_after_retire", 32'(bus.count), 32'd7);
        doAlloc(7'd50, 7'd3, 1'b1, 3'd0, 1'b1, 1'b1);
        checkOutput("t3_count_refill", 32'(bus.count), 32'd8);
        for (int i = 1; i < 8; i++)
            doResolve(3'(i), 1'(i));
        doResolve(3'd0, 1'b1);
        waitDrain(20);
        checkOutput("t3_count_final", 32'(bus.count), 32'd0);

        // Squash: younger resolved entries are discarded, alloc blocked in squash cycle
        doReset(1);
        for (int i = 0; i < 5; i++)
            doAlloc(7'(40 + i), 7'(8 * i), 1'b1, 3'(i), (i != 0), (i == 0));
        doResolve(3'd3, 1'b1);
        doResolve(3'd4, 1'b1);
        doResolve(3'd0, 1'b0);
        checkOutput("t4_squash_ready", 32'(bus.alloc_ready), 32'd0);
        checkOutput("t4_count_before", 32'(bus.count), 32'd5);
        applyStimulus(1'b1, 7'd77, 7'd0, 1'b1, 1'b1, 3'd1, 1'b1);
        checkOutput("t4_train_valid", 32'(bus.train_valid), 32'd1);
        checkOutput("t4_count_after", 32'(bus.count), 32'd0);
        checkOutput("t4_next_tag", 32'(bus.alloc_tag), 32'd1);
        checkOutput("t4_no_err_in_squash", 32'(bus.resolve_err), 32'd0);
        doAlloc(7'd60, 7'd0, 1'b1, 3'd1, 1'b1, 1'b0);
        checkOutput("t4_count_realloc", 32'(bus.count), 32'd1);
        doResolve(3'd3, 1'b1);
        checkOutput("t4_late_resolve_err", 32'(bus.resolve_err), 32'd1);
        cycle();
        cycle();
        checkOutput("t4_train_quiet", 32'(bus.train_valid), 32'd0);
        waitDrain(2);

        // Reset mid-operation, including a resolve that would retire at the reset edge
        doReset(1);
        for (int i = 0; i < 4; i++)
            doAlloc(7'(i + 1), 7'(i), 1'b1, 3'(i), 1'b1, 1'b0);
        checkOutput("t6_alloc_tag4", 32'(bus.alloc_tag), 32'd4);
        applyStimulus(1'b1, 7'd9, 7'd9, 1'b1, 1'b1, 3'd4, 1'b1);
        checkOutput("t6_same_cycle_err", 32'(bus.resolve_err), 32'd1);
        checkOutput("t6_count5", 32'(bus.count), 32'd5);
        doResolve(3'd0, 1'b1);
        doReset(1);
        checkOutput("t6_train_valid", 32'(bus.train_valid), 32'd0);
        checkOutput("t6_count", 32'(bus.count), 32'd0);
        checkOutput("t6_alloc_tag", 32'(bus.alloc_tag), 32'd0);
        checkOutput("t6_resolve_err", 32'(bus.resolve_err), 32'd0);
        cycle();
        checkOutput("t6_train_still_idle", 32'(bus.train_valid), 32'd0);
        doAlloc(7'd5, 7'd5, 1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("t6_count_after_alloc", 32'(bus.count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
